// File: rtl/stim_seq.sv
// Stimulus sequencer: emits N pulses on pclk1/pclk2/parst (or waits), then snapshots cnt1/cnt2.
// Optional macro DOUBLE_ARST_EN: each ARST period emits two parst pulses instead of one.
module stim_seq #(
  parameter int HIGH_CYC = 5,
  parameter int LOW_CYC  = 5,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [7:0]    cmd_rep,
  output logic          pclk1,
  output logic          pclk2,
  output logic          parst,
  input  logic [CW-1:0] cnt1,
  input  logic [CW-1:0] cnt2,
  output logic          snap_valid,
  output logic [CW-1:0] snap_cnt1,
  output logic [CW-1:0] snap_cnt2,
  output logic          busy
);
  localparam logic [1:0] OP_CLK1 = 2'd0;
  localparam logic [1:0] OP_CLK2 = 2'd1;
  localparam logic [1:0] OP_ARST = 2'd2;
  localparam int MAXC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int PW   = $clog2(MAXC + 1);
  localparam logic [PW-1:0] PH_HI_END = PW'(HIGH_CYC - 1);
  localparam logic [PW-1:0] PH_LO_END = PW'(LOW_CYC - 1);

  typedef enum logic [1:0] {IDLE, HI, LO, SNAP} state_t;

  state_t        state, state_n;
  logic [1:0]    op, op_n;
  logic [7:0]    rep, rep_n;
  logic [PW-1:0] ph, ph_n;
  logic          sec, sec_n;

  always_comb begin
    state_n = state;
    op_n    = op;
    rep_n   = rep;
    ph_n    = ph;
    sec_n   = sec;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        op_n    = cmd_op;
        rep_n   = cmd_rep;
        ph_n    = '0;
        sec_n   = 1'b0;
        state_n = (cmd_rep == 8'd0) ? SNAP : HI;
      end
      HI: if (ph == PH_HI_END) begin
        ph_n    = '0;
        state_n = LO;
      end else begin
        ph_n = ph + PW'(1);
      end
      LO: if (ph == PH_LO_END) begin
        ph_n = '0;
`ifdef DOUBLE_ARST_EN
        // first pass of an ARST period loops back for a second pulse without consuming rep
        if (op == OP_ARST && !sec) begin
          sec_n   = 1'b1;
          state_n = HI;
        end else begin
          sec_n   = 1'b0;
          rep_n   = rep - 8'd1;
          state_n = (rep == 8'd1) ? SNAP : HI;
        end
`else
        rep_n   = rep - 8'd1;
        state_n = (rep == 8'd1) ? SNAP : HI;
`endif
      end else begin
        ph_n = ph + PW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // outputs are registered from next-state so pulses start the cycle after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op         <= '0;
      rep        <= '0;
      ph         <= '0;
      sec        <= 1'b0;
      pclk1      <= 1'b0;
      pclk2      <= 1'b0;
      parst      <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b0;
      snap_valid <= 1'b0;
      snap_cnt1  <= '0;
      snap_cnt2  <= '0;
    end else begin
      state      <= state_n;
      op         <= op_n;
      rep        <= rep_n;
      ph         <= ph_n;
      sec        <= sec_n;
      pclk1      <= (state_n == HI) && (op_n == OP_CLK1);
      pclk2      <= (state_n == HI) && (op_n == OP_CLK2);
      parst      <= (state_n == HI) && (op_n == OP_ARST);
      busy       <= (state_n != IDLE);
      cmd_ready  <= (state_n == IDLE);
      snap_valid <= (state == SNAP);
      if (state == SNAP) begin
        snap_cnt1 <= cnt1;
        snap_cnt2 <= cnt2;
      end
    end
  end
endmodule

// File: tb/tb_stim_seq.sv
// Directed bench for stim_seq with a behavioural two-clock counter model on its outputs.
module tb_stim_seq;
  localparam int HC = 5;
  localparam int LC = 5;
`ifdef DOUBLE_ARST_EN
  localparam int NA = 2;
`else
  localparam int NA = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_rep = 8'd0;
  logic       pclk1, pclk2, parst;
  logic [7:0] cnt1 = 8'd0;
  logic [7:0] cnt2 = 8'd0;
  logic       snap_valid, busy;
  logic [7:0] snap_cnt1, snap_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  stim_seq #(.HIGH_CYC(HC), .LOW_CYC(LC), .CW(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rep(cmd_rep), .pclk1(pclk1), .pclk2(pclk2), .parst(parst),
    .cnt1(cnt1), .cnt2(cnt2), .snap_valid(snap_valid), .snap_cnt1(snap_cnt1),
    .snap_cnt2(snap_cnt2), .busy(busy)
  );

  always #5 clk = ~clk;

  // counter DUT model: count on rising pulse clock, clear while parst high
  always @(posedge pclk1 or posedge parst) if (parst) cnt1 <= 8'd0; else cnt1 <= cnt1 + 8'd1;
  always @(posedge pclk2 or posedge parst) if (parst) cnt2 <= 8'd0; else cnt2 <= cnt2 + 8'd1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [7:0] rep,
                     input int exp_cyc, input int exp_c1, input int exp_c2);
    int hi[3];
    int rise[3];
    logic [2:0] prev;
    logic [2:0] cur;
    int sv_cyc;
    int overlap;
    int p;
    int k;
    hi = '{0, 0, 0};
    rise = '{0, 0, 0};
    prev = 3'b000;
    sv_cyc = -1;
    overlap = 0;
    k = 0;
    while (!cmd_ready && k < 100) begin step(); k++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_rep = rep;
    step();
    cmd_valid = 1'b0;
    chk({tag, " busy@1"}, int'(busy), 1);
    chk({tag, " ready@1"}, int'(cmd_ready), 0);
    for (int c = 1; c <= 700; c++) begin
      cur = {parst, pclk2, pclk1};
      if ($countones(cur) > 1) overlap++;
      for (int i = 0; i < 3; i++) begin
        if (cur[i]) hi[i]++;
        if (cur[i] && !prev[i]) rise[i]++;
      end
      prev = cur;
      if (snap_valid) begin sv_cyc = c; break; end
      step();
    end
    chk({tag, " snap_cycle"}, sv_cyc, exp_cyc);
    chk({tag, " snap_cnt1"}, int'(snap_cnt1), exp_c1);
    chk({tag, " snap_cnt2"}, int'(snap_cnt2), exp_c2);
    chk({tag, " ready@snap"}, int'(cmd_ready), 1);
    chk({tag, " busy@snap"}, int'(busy), 0);
    chk({tag, " overlap"}, overlap, 0);
    for (int i = 0; i < 3; i++) begin
      p = (op == 2'd3 || int'(op) != i) ? 0 : int'(rep) * ((op == 2'd2) ? NA : 1);
      chk($sformatf("%s hi_cycles[%0d]", tag, i), hi[i], p * HC);
      chk($sformatf("%s rises[%0d]", tag, i), rise[i], p);
    end
    step();
    chk({tag, " snap_one_cycle"}, int'(snap_valid), 0);
    chk({tag, " snap_hold1"}, int'(snap_cnt1), exp_c1);
  endtask

  initial begin
    int bad;
    repeat (3) step();
    chk("rst pclk", int'({pclk1, pclk2, parst}), 0);
    chk("rst snap", int'({snap_valid, snap_cnt1, snap_cnt2}), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst ready", int'(cmd_ready), 0);
    rst = 1'b0;
    step();
    chk("ready after rst", int'(cmd_ready), 1);

    run("arst1", 2'd2, 8'd1, NA * (HC + LC) + 2, 0, 0);
    run("clk1x5", 2'd0, 8'd5, 52, 5, 0);
    run("arst2", 2'd2, 8'd1, NA * (HC + LC) + 2, 0, 0);
    run("clk2x5", 2'd1, 8'd5, 52, 0, 5);
    run("wait3", 2'd3, 8'd3, 32, 0, 5);
    run("rep0", 2'd0, 8'd0, 2, 0, 5);

    // reset in the third HI of CLK2 x5, with a second command held on cmd_valid
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rep = 8'd5;
    step();
    cmd_op = 2'd0; cmd_rep = 8'd1;
    bad = 0;
    for (int c = 1; c < 22; c++) begin
      if (pclk1 || cmd_ready) bad++;
      step();
    end
    chk("held cmd not consumed", bad, 0);
    chk("pclk2 in 3rd HI", int'(pclk2), 1);
    chk("cnt2 before rst", int'(cnt2), 8);
    rst = 1'b1; cmd_valid = 1'b0;
    step();
    chk("midrst pclk2", int'(pclk2), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst ready", int'(cmd_ready), 0);
    rst = 1'b0;
    step();
    chk("ready after midrst", int'(cmd_ready), 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (snap_valid || pclk1 || pclk2 || parst || busy) bad++;
      step();
    end
    chk("no snap after midrst", bad, 0);

    run("arst3", 2'd2, 8'd1, NA * (HC + LC) + 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stim_seq.md
Name: stim_seq

Overview:
- Synthesizable stimulus sequencer that drives the two-clock counter DUT from a single system clock.
- Executes one command at a time, taken over a valid/ready interface. Each command generates N pulses on pclk1, pclk2 or parst, or an idle wait.
- On command completion, snapshots the DUT's cnt1/cnt2 and presents them as a one-cycle record. This is the hardware equivalent of a "pulse, then display" step.
- Sits directly upstream of the DUT (drives its clocks and reset) and also consumes its counter outputs.

Parameters:
- HIGH_CYC, 5, system-clock cycles each generated pulse is held high (>=1)
- LOW_CYC, 5, system-clock cycles each generated pulse is held low afterwards (>=1)
- CW, 8, DUT counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  0=CLK1, 1=CLK2, 2=ARST, 3=WAIT
- cmd_rep  in  8  number of pulse periods
- pclk1  out  1  DUT clock 1
- pclk2  out  1  DUT clock 2
- parst  out  1  DUT reset pulse
- cnt1  in  CW  DUT counter 1
- cnt2  in  CW  DUT counter 2
- snap_valid  out  1  one-cycle strobe: snapshot valid
- snap_cnt1  out  CW  captured cnt1
- snap_cnt2  out  CW  captured cnt2
- busy  out  1  command in progress

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values: pclk1/pclk2/parst=0, snap_valid=0, snap_cnt1/snap_cnt2=0, busy=0, cmd_ready=0 while rst=1.
- cmd_ready=1 from the first edge after rst deasserts, whenever the state is IDLE.
- States: IDLE, HI, LO, SNAP.
- IDLE: on cmd_valid && cmd_ready, latch op and rep, and set busy=1.
  - rep==0: go to SNAP.
  - rep!=0: go to HI.
  - cmd_ready=0 in all non-IDLE states.
- HI: the selected output (pclk1, pclk2 or parst; none for WAIT) is 1 for exactly HIGH_CYC cycles, starting the cycle after acceptance. Then go to LO.
- LO: all pulse outputs are 0 for LOW_CYC cycles. At the end, decrement rep.
  - rep==0: go to SNAP.
  - otherwise: go to HI.
- SNAP, one cycle:
  - capture cnt1/cnt2 into snap_cnt1/snap_cnt2;
  - snap_valid=1 on the following cycle, together with the return to IDLE;
  - busy=0;
  - cmd_ready=1 in that same cycle.
- Snapshots hold until the next SNAP.
- Timing: command duration from acceptance to snap_valid is rep*(HIGH_CYC+LOW_CYC)+2 cycles. Back-to-back commands may be accepted in the cycle snap_valid is high.
- At most one of pclk1/pclk2/parst is high in any cycle. Pulse outputs are glitch-free because they come straight from flops.
- Phase counter width is clog2(max(HIGH_CYC,LOW_CYC)+1). The rep counter is 8 bits and does not wrap, since it only decrements from a nonzero value.
- cnt1/cnt2 are treated as settled at sampling time: at least LOW_CYC cycles have elapsed since the last pulse edge. No synchronizer is included.
- Reset mid-command: at the next edge, all pulse outputs are 0 and the state is IDLE. The command is discarded and no snap_valid is produced.
- cmd_valid while busy is ignored (not consumed). The upstream must hold the command until cmd_ready.

Optional Feature:
- Macro: DOUBLE_ARST_EN.
- Defined: each ARST period emits two parst pulses instead of one, each pulse HIGH_CYC high then LOW_CYC low. ARST duration is therefore rep*2*(HIGH_CYC+LOW_CYC)+2 cycles. Implemented as an extra LO-to-HI pass per period.
- Undefined: ARST behaves like the other ops (one pulse per period).
- CLK1/CLK2/WAIT are unaffected in both cases.

Test Plan:
Bench model: DUT counters increment on the rising edge of pclk1/pclk2 and clear while parst=1. Defaults H=L=5.

1. Release rst, then send ARST rep=1 -> parst high for cycles 1-5 after acceptance; snap_valid at cycle 12; snap=(0,0).
2. CLK1 rep=5 -> exactly 5 pclk1 pulses, period 10; pclk2/parst stay 0; snap_valid at cycle 52; snap=(5,0).
3. ARST rep=1 after step 2, then CLK2 rep=5 -> snaps (0,0), then (0,5).
4. WAIT rep=3 -> no pulse output toggles; snap_valid at cycle 32; rep=0 with any op -> snap_valid at cycle 2 with no pulses.
5. Assert rst during the 3rd HI of a CLK2 rep=5 -> pclk2=0 the next edge; no snap_valid; cmd_ready=1 one cycle after rst release; cmd_valid held during busy is not consumed.
6. With DOUBLE_ARST_EN: ARST rep=1 -> two parst pulses with rising edges 10 cycles apart; snap_valid at cycle 22. Without the macro -> one pulse; snap_valid at cycle 12.
